dcache_ctrl: RTL and testbench

- Sequencing controller for the data-side path: owns a direct-mapped, write-through, no-write-allocate cache (tag/valid/data arrays) and issues handshaked requests to a multi-cycle backing data memory.
- Sits between the CPU load/store datapath and data memory, stalling the CPU (cpu_ready low) until each access completes.

---
 rtl/dcache_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with a handshaked
// backing-memory port. Optional hit/miss counters enabled by defining DCACHE_PERF_CNT_EN.
module dcache_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              flush,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int unsigned Lines = 2 ** INDEX_BITS;
    localparam int unsigned TagW  = ADDR_W - INDEX_BITS - 2;

    typedef enum logic [1:0] {StIdle, StLookup, StMem, StResp} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;

    logic [Lines-1:0]    valid_q;
    logic [TagW-1:0]     tag_q [Lines];
    logic [DATA_W-1:0]   data_q [Lines];

    logic [INDEX_BITS-1:0] idx;
    logic [TagW-1:0]       tag;
    logic                  hit, flush_en, line_fill, line_wr;

    assign idx = addr_q[INDEX_BITS+1:2];
    assign tag = addr_q[ADDR_W-1:INDEX_BITS+2];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        flush_en    = 1'b0;
        line_fill   = 1'b0;
        line_wr     = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (flush) begin
                    flush_en = 1'b1;
`ifdef DCACHE_PERF_CNT_EN
                    hit_cnt_d  = '0;
                    miss_cnt_d = '0;
`endif
                end else if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = StLookup;
                end
            end
            StLookup: begin
`ifdef DCACHE_PERF_CNT_EN
                if (hit) begin
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
                end else if (miss_cnt_q != '1) begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                end
`endif
                if (!we_q && hit) begin
                    cpu_rdata_d = data_q[idx];
                    cpu_ready_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    // Stores always go through to memory; the line is only updated on a hit.
                    mem_req_d  = 1'b1;
                    mem_we_d   = we_q;
                    mem_addr_d = addr_q;
                    if (we_q) mem_wdata_d = wdata_q;
                    line_wr    = we_q && hit;
                    state_d    = StMem;
                end
            end
            StMem: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    cpu_ready_d = 1'b1;
                    if (!we_q) begin
                        line_fill   = 1'b1;
                        cpu_rdata_d = mem_rdata;
                    end
                    state_d = StResp;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            if (flush_en) valid_q <= '0;
            else if (line_fill) valid_q[idx] <= 1'b1;
        end
    end

    // Tag/data storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (line_fill) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem_rdata;
        end else if (line_wr) begin
            data_q[idx] <= wdata_q;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl: hits, misses, write-through, eviction,
// flush priority and reset mid-transaction.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        flush = 1'b0;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    dcache_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .flush     (flush),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit exp_mem, input int ack_delay,
                          input logic [31:0] mdata, input logic [31:0] exp_rdata);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(negedge clk);
        check({tag, " lookup ready"}, 32'(cpu_ready), 32'd0);
        check({tag, " lookup busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        if (!exp_mem) begin
            check({tag, " hit ready"}, 32'(cpu_ready), 32'd1);
            check({tag, " hit no mem_req"}, 32'(mem_req), 32'd0);
        end else begin
            check({tag, " mem_req"}, 32'(mem_req), 32'd1);
            check({tag, " mem_we"}, 32'(mem_we), 32'(we));
            check({tag, " mem_addr"}, mem_addr, addr);
            if (we) check({tag, " mem_wdata"}, mem_wdata, wdata);
            for (int i = 1; i < ack_delay; i++) begin
                @(negedge clk);
                check({tag, " mem_req held"}, 32'(mem_req), 32'd1);
                check({tag, " no early ready"}, 32'(cpu_ready), 32'd0);
            end
            mem_ack = 1'b1; mem_rdata = mdata;
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = 32'hDEAD_0000;
            check({tag, " ready after ack"}, 32'(cpu_ready), 32'd1);
            check({tag, " mem_req dropped"}, 32'(mem_req), 32'd0);
        end
        if (!we) check({tag, " rdata"}, cpu_rdata, exp_rdata);
        cpu_req = 1'b0;
        @(negedge clk);
        check({tag, " ready one cycle"}, 32'(cpu_ready), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        if (!we) check({tag, " rdata held"}, cpu_rdata, exp_rdata);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst cpu_rdata", cpu_rdata, 32'd0);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst busy", 32'(busy), 32'd0);

        access("rd40 miss", 1'b0, 32'h40, '0, 1'b1, 3, 32'h1234, 32'h1234);
        access("rd40 hit", 1'b0, 32'h40, '0, 1'b0, 0, '0, 32'h1234);
        access("wr40 hit", 1'b1, 32'h40, 32'hBEEF, 1'b1, 2, '0, '0);
        access("rd40 after wr", 1'b0, 32'h40, '0, 1'b0, 0, '0, 32'hBEEF);
        access("wr80 miss", 1'b1, 32'h80, 32'h5, 1'b1, 1, '0, '0);
        access("rd80 no alloc", 1'b0, 32'h80, '0, 1'b1, 2, 32'h5, 32'h5);
        access("rd40 evicted", 1'b0, 32'h40, '0, 1'b1, 1, 32'hBEEF, 32'hBEEF);
        access("rd80 evicted", 1'b0, 32'h80, '0, 1'b1, 1, 32'h5, 32'h5);
        access("rd40 refill", 1'b0, 32'h40, '0, 1'b1, 4, 32'hBEEF, 32'hBEEF);
        access("rd44 miss", 1'b0, 32'h44, '0, 1'b1, 1, 32'hA5A5, 32'hA5A5);
        access("rd40 other idx", 1'b0, 32'h40, '0, 1'b0, 0, '0, 32'hBEEF);
        access("rd44 hit", 1'b0, 32'h44, '0, 1'b0, 0, '0, 32'hA5A5);

        // Flush together with a request: flush wins, request is not taken.
        @(negedge clk);
        flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        @(negedge clk);
        check("flush busy", 32'(busy), 32'd0);
        check("flush no mem_req", 32'(mem_req), 32'd0);
`ifdef DCACHE_PERF_CNT_EN
        check("flush hit_cnt", hit_cnt, 32'd0);
        check("flush miss_cnt", miss_cnt, 32'd0);
`endif
        flush = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("flush still idle", 32'(busy), 32'd0);
        access("rd40 after flush", 1'b0, 32'h40, '0, 1'b1, 1, 32'h77, 32'h77);

        // Reset while a miss is outstanding.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h84;
        repeat (2) @(negedge clk);
        check("pre-rst mem_req", 32'(mem_req), 32'd1);
        cpu_req = 1'b0;
        reset = 1'b0;
        #1;
        check("async rst mem_req", 32'(mem_req), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h9999;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late ack ready", 32'(cpu_ready), 32'd0);
        check("late ack busy", 32'(busy), 32'd0);
        check("late ack rdata", cpu_rdata, 32'd0);
`ifdef DCACHE_PERF_CNT_EN
        check("rst hit_cnt", hit_cnt, 32'd0);
        check("rst miss_cnt", miss_cnt, 32'd0);
`endif
        access("rd40 after rst", 1'b0, 32'h40, '0, 1'b1, 1, 32'h55, 32'h55);
        access("rd44 after rst", 1'b0, 32'h44, '0, 1'b1, 1, 32'h66, 32'h66);
`ifdef DCACHE_PERF_CNT_EN
        check("cnt miss", miss_cnt, 32'd2);
        check("cnt hit", hit_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
